// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - registered 4-bit carry-lookahead adder with group propagate/generate
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     asynchronous active-low reset
//   A, B      4-bit unsigned operands
//   Cin       carry-in
//   in_valid  operands valid this cycle; capture enable
//   Sum       registered low 4 bits of A+B+Cin
//   Cout      registered carry-out (bit 4 of A+B+Cin)
//   Pg        registered group propagate
//   Gg        registered group generate (independent of Cin)
//   out_valid outputs hold a result captured on the previous edge

module cla_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  input  logic       in_valid,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Pg,
  output logic       Gg,
  output logic       out_valid
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1, c2, c3, c4;
  logic       gg_c;
  logic       pg_c;
  logic [3:0] sum_c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat sum-of-products of the P/G terms and Cin, so no
  // carry waits on a lower computed carry: two levels past the P/G gates.
  assign c1 = g[0]
            | (p[0] & Cin);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & Cin);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & Cin);
  assign c4 = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & Cin);

  // Group terms for a second-level lookahead unit; Cout == Gg | (Pg & Cin).
  assign gg_c = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign pg_c = &p;

  assign sum_c = p ^ {c3, c2, c1, Cin};

  // Results hold when in_valid is low; only out_valid tracks every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= 4'b0000;
      Cout      <= 1'b0;
      Pg        <= 1'b0;
      Gg        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= c4;
        Pg   <= pg_c;
        Gg   <= gg_c;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// tb/tb_cla_adder.sv - scoreboard bench for cla_adder

module tb_cla_adder;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       pg;
    logic       gg;
    logic       vld;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum;
  logic       cout;
  logic       pg;
  logic       gg;
  logic       out_valid;

  int   n_assert;
  int   n_fail;
  res_t sb[$];
  res_t held;

  cla_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .in_valid (in_valid),
    .Sum      (sum),
    .Cout     (cout),
    .Pg       (pg),
    .Gg       (gg),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Arithmetic reference: Gg is the carry-out of A+B with no carry-in,
  // Pg is set when every bit position propagates.
  function automatic res_t model(input logic [3:0] x, input logic [3:0] y, input logic c);
    res_t       r;
    logic [4:0] t;
    logic [4:0] t0;
    t  = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    t0 = {1'b0, x} + {1'b0, y};
    r.sum  = t[3:0];
    r.cout = t[4];
    r.gg   = t0[4];
    r.pg   = ((x ^ y) == 4'hF);
    r.vld  = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input res_t e);
    chk({tag, ".sum"},       sum,               e.sum);
    chk({tag, ".cout"},      {3'b000, cout},      {3'b000, e.cout});
    chk({tag, ".pg"},        {3'b000, pg},        {3'b000, e.pg});
    chk({tag, ".gg"},        {3'b000, gg},        {3'b000, e.gg});
    chk({tag, ".out_valid"}, {3'b000, out_valid}, {3'b000, e.vld});
  endtask

  // One cycle: drive at the falling edge, capture at the rising edge,
  // compare 1 time unit after it against the scoreboard or the held value.
  task automatic step(input string tag, input logic [3:0] x, input logic [3:0] y,
                      input logic c, input logic v);
    res_t e;
    @(negedge clk);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = v;
    if (v) sb.push_back(model(x, y, c));
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        return;
      end
      e    = sb.pop_front();
      held = e;
    end else begin
      e     = held;
      e.vld = 1'b0;
    end
    chk_all(tag, e);
  endtask

  task automatic expect_fixed(input string tag, input logic [3:0] s, input logic co,
                              input logic p_exp, input logic g_exp);
    chk({tag, ".fixed_sum"},  sum,          s);
    chk({tag, ".fixed_cout"}, {3'b000, cout}, {3'b000, co});
    chk({tag, ".fixed_pg"},   {3'b000, pg},   {3'b000, p_exp});
    chk({tag, ".fixed_gg"},   {3'b000, gg},   {3'b000, g_exp});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    held     = '0;
    rst_n    = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    cin      = 1'b0;
    in_valid = 1'b0;

    #12;
    chk_all("reset", res_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle edge after reset: nothing captured yet.
    step("idle", 4'h9, 4'h9, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          step("sweep", 4'(i), 4'(j), 1'(k), 1'b1);

    step("full_carry", 4'hF, 4'h1, 1'b0, 1'b1);
    expect_fixed("full_carry", 4'h0, 1'b1, 1'b0, 1'b1);

    step("prop_cin1", 4'h7, 4'h8, 1'b1, 1'b1);
    expect_fixed("prop_cin1", 4'h0, 1'b1, 1'b1, 1'b0);

    step("prop_cin0", 4'h7, 4'h8, 1'b0, 1'b1);
    expect_fixed("prop_cin0", 4'hF, 1'b0, 1'b1, 1'b0);

    step("hold_cap", 4'h3, 4'h5, 1'b0, 1'b1);
    expect_fixed("hold_cap", 4'h8, 1'b0, 1'b0, 1'b0);
    step("hold1", 4'hC, 4'hA, 1'b1, 1'b0);
    step("hold2", 4'h5, 4'h3, 1'b0, 1'b0);
    step("hold3", 4'hF, 4'hF, 1'b1, 1'b0);
    chk("hold3.fixed_sum", sum, 4'h8);

    // Asynchronous reset between edges while Sum=E.
    step("pre_reset", 4'h7, 4'h7, 1'b0, 1'b1);
    chk("pre_reset.fixed_sum", sum, 4'hE);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", res_t'(0));
    sb.delete();
    held = '0;
    @(negedge clk);
    rst_n = 1'b1;

    step("post_reset", 4'hF, 4'hF, 1'b1, 1'b1);
    expect_fixed("post_reset", 4'hF, 1'b1, 1'b0, 1'b1);

    step("b2b_0", 4'h1, 4'h1, 1'b0, 1'b1);
    expect_fixed("b2b_0", 4'h2, 1'b0, 1'b0, 1'b0);
    step("b2b_1", 4'h8, 4'h8, 1'b0, 1'b1);
    expect_fixed("b2b_1", 4'h0, 1'b1, 1'b0, 1'b1);
    step("b2b_2", 4'hF, 4'h0, 1'b1, 1'b1);
    expect_fixed("b2b_2", 4'h0, 1'b1, 1'b1, 1'b0);

    step("final_idle", 4'h0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
# cla_adder

Registered 4-bit carry-lookahead adder. Adds two 4-bit operands plus a carry-in, computing all internal carries in parallel from per-bit generate/propagate terms rather than by ripple. Exposes group propagate/generate so instances can be cascaded under a second-level lookahead unit. It is the arithmetic leaf of the datapath. Results are captured in an output register with a valid flag.

## Interface

Parameters: none; width fixed at 4 bits.

Clock and reset are decided: one clock; reset is asynchronous and active-low.

- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset
- A  input  4  operand A, unsigned
- B  input  4  operand B, unsigned
- Cin  input  1  carry-in
- in_valid  input  1  operands valid this cycle; capture enable
- Sum  output  4  registered A+B+Cin, low 4 bits
- Cout  output  1  registered carry-out (bit 4 of A+B+Cin)
- Pg  output  1  registered group propagate, P3&P2&P1&P0
- Gg  output  1  registered group generate
- out_valid  output  1  Sum/Cout/Pg/Gg hold a result captured on the previous edge

## Operation

Per-bit terms:
- Gi = Ai & Bi
- Pi = Ai ^ Bi
- C0 = Cin

Carries, each as a flat sum-of-products with no chained dependence on a lower computed carry:
- C1 = G0 | P0C0
- C2 = G1 | P1G0 | P1P0C0
- C3 = G2 | P2G1 | P2P1G0 | P2P1P0C0
- C4 = G3 | P3G2 | P3P2G1 | P3P2P1G0 | P3P2P1P0C0

Outputs:
- Si = Pi ^ Ci
- Cout = C4
- Gg = G3 | P3G2 | P3P2G1 | P3P2P1G0, independent of Cin
- Pg = P3&P2&P1&P0
- Identity: Cout == Gg | (Pg & Cin) for every input combination.

Arithmetic:
- {Cout,Sum} equals A+B+Cin as a 5-bit unsigned value for all 512 input combinations.
- No overflow flag. Signed interpretation is left to the consumer.

Capture:
- When in_valid=1 at a rising edge, Sum, Cout, Pg and Gg load the combinational results, and out_valid loads 1.
- When in_valid=0 at a rising edge, Sum, Cout, Pg and Gg hold their previous values, and out_valid loads 0.

## Timing

- Latency: exactly 1 cycle. Operands sampled at edge N appear on the outputs after edge N and stay stable until the next capture.
- Throughput: one add per cycle. Back-to-back in_valid is supported with no bubbles.
- Reset (rst_n low): Sum=4'b0000, Cout=0, Pg=0, Gg=0, out_valid=0.
  - Reset takes effect immediately, without waiting for a clock edge.
  - Reset mid-operation discards any in-flight result.
- First capture: occurs on the first rising edge after rst_n deasserts on which in_valid=1.
- Combinational path: A/B/Cin to the register D inputs has a depth of two logic levels beyond the P/G gates, regardless of bit position.
- Input requirement: inputs must be stable for setup/hold around clk. The block does no internal input registering.
- No handshake backpressure: a consumer must take the result while out_valid=1, or read the held value later.

## Test plan

- Exhaustive sweep of A=0..15, B=0..15, Cin=0 and Cin=1, with in_valid=1:
  - each result is checked one cycle later against {Cout,Sum}=A+B+Cin;
  - Pg and Gg are checked against the formulas above;
  - 512 checks, zero mismatches.
- Full-carry chain: A=4'hF, B=4'h1, Cin=0 -> Sum=4'h0, Cout=1, Gg=1, Pg=0.
- Pure propagate: A=4'h7, B=4'h8.
  - Cin=1 -> Sum=4'h0, Cout=1, Pg=1, Gg=0.
  - Cin=0 -> Sum=4'hF, Cout=0.
- Hold behaviour:
  - Capture A=3, B=5, Cin=0 -> Sum=8, Cout=0, out_valid=1.
  - Then drop in_valid for 3 cycles while A and B toggle -> Sum stays 8, out_valid=0.
- Asynchronous reset:
  - Assert rst_n low between clock edges while Sum=4'hE -> all outputs 0 before the next edge.
  - Release, then apply A=4'hF, B=4'hF, Cin=1 -> Sum=4'hF, Cout=1 one cycle later.
- Back-to-back operation: stream (1,1,0), (8,8,0), (15,0,1) on consecutive cycles -> outputs (2,0), (0,1), (0,1) on consecutive cycles, with out_valid continuously 1.
